cpu_controller: RTL and testbench
=================================

# cpu_controller

Instruction-sequencing controller for the 8-bit RISC CPU. Owns an internal 3-bit phase counter and decodes the current phase, the 3-bit instruction opcode and the ALU `is_zero` flag into the per-cycle control strobes for the PC, IR, memory, accumulator and data bus. It sits between the instruction register and the datapath, and it decides when the ALU result is captured into the accumulator. Every instruction takes exactly 8 clock cycles, except HLT, which freezes the machine until reset.

## Interface
- No parameters. Opcode width is 3 and the phase count is 8, both fixed.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 3: current IR opcode field.
  - 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- `zero` input 1: ALU `is_zero` (accumulator == 0).
- `sel` output 1: address mux select; 1 = PC, 0 = IR operand.
- `rd` output 1: memory read enable.
- `ld_ir` output 1: instruction register load.
- `inc_pc` output 1: PC increment.
- `ld_pc` output 1: PC load from the IR operand.
- `ld_ac` output 1: accumulator load from the ALU output.
- `wr` output 1: memory write strobe.
- `data_e` output 1: accumulator drives the data bus.
- `halt` output 1: CPU halted.
- `phase` output 3: current phase, for debug and bench visibility.

## Operation
- State consists of `phase` (3 bits, registered) and `halted` (1 bit, registered).
- All strobes are combinational decodes of `phase`, `opcode`, `zero` and `halted`. They are Moore-style with respect to `phase`.
- While not halted, `phase` increments by 1 every cycle and wraps from 7 to 0.
- ALUOP is defined as opcode ∈ {ADD, AND, XOR, LDA}.
- Phase decode (any strobe not listed is 0):
  - 0 INST_ADDR: `sel`=1.
  - 1 INST_FETCH: `sel`=1, `rd`=1.
  - 2 INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1.
  - 3 IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
  - 4 OP_ADDR: `inc_pc`=(opcode≠HLT), `halt`=(opcode==HLT).
  - 5 OP_FETCH: `rd`=ALUOP.
  - 6 ALU_OP: `rd`=ALUOP, `inc_pc`=(SKZ & `zero`), `ld_pc`=JMP, `data_e`=STO.
  - 7 STORE: `rd`=ALUOP, `ld_ac`=ALUOP, `ld_pc`=JMP, `wr`=STO, `data_e`=STO.
- HLT handling:
  - `halted` is set on the rising edge that ends phase 4 when opcode==HLT. `phase` stays at 4.
  - While halted: `phase` is frozen at 4, `halt`=1, and every other strobe is 0 regardless of `opcode` and `zero`.
  - Only `rst` clears `halted`.
- `wr` and `ld_pc` are never asserted in phases 0–5.
- `ld_ac` and `wr` are never asserted in the same cycle.

## Timing
- Reset (asynchronous assert, immediate):
  - `phase`=0, `halted`=0.
  - Outputs: `sel`=1, all other strobes 0, `halt`=0.
- After reset release, the first rising edge moves `phase` 0→1.
- Reset asserted mid-instruction returns to phase 0 immediately and abandons the instruction. No partial `wr` or `ld_ac` may occur after `rst` rises.
- Strobe timing: each strobe is valid for the full cycle of its phase. Consumers capture on the rising edge that ends that phase:
  - IR is captured at the end of phase 2 (held through 3).
  - The accumulator is captured at the end of phase 7.
- `opcode` is required stable from phase 3 to phase 7. Changes in phases 0–2 have no effect on strobes.
- `zero` is sampled only in phase 6.
  - A SKZ with `zero`=1 gives two `inc_pc` pulses in the instruction (phases 4 and 6).
  - With `zero`=0 it gives one.
- Latency: fixed 8 cycles per instruction; HLT reaches the halted state after 5 cycles (end of phase 4).

## Test plan
- Reset: hold `rst`=1 for 3 cycles, then release.
  - Required during reset: `phase`=0, `sel`=1, all other strobes 0.
  - Required after release: `phase` reads 1,2,…,7,0 on successive edges with opcode=ADD.
- ADD (opcode=010, `zero`=0) over one 8-cycle instruction.
  - Required: `rd` high in phases 1,2,3,5,6,7; `ld_ir` high in phases 2–3; `inc_pc` high in phase 4 only; `ld_ac` high in phase 7 only; `wr`=`data_e`=`ld_pc`=0 throughout.
- SKZ (opcode=001):
  - With `zero`=1 → `inc_pc` high in phases 4 and 6.
  - With `zero`=0 → `inc_pc` high in phase 4 only.
  - In both cases `rd`=0 in phases 5–7 and `ld_ac`=0.
- STO (110) and JMP (111):
  - STO → `data_e` high in phases 6–7, `wr` high in phase 7 only, `ld_ac`=0.
  - JMP → `ld_pc` high in phases 6–7, `wr`=0.
- HLT (000): run to phase 4.
  - Required in phase 4: `halt`=1, `inc_pc`=0.
  - Required for the next 10 cycles: `phase` stays 4, `halt`=1, all strobes 0, even when opcode is toggled to 010 and `zero` is toggled.
  - Then assert `rst` → `phase`=0, `halt`=0 without waiting for a clock edge.
- Reset mid-operation: assert `rst` asynchronously (between edges) during phase 7 of a STO.
  - Required: `wr` drops immediately, `phase`=0.
  - After release, the next instruction starts from phase 0 with normal timing.

Source files
------------

// File: rtl/cpu_controller.sv
// Instruction-sequencing controller for the 8-bit RISC CPU: an 8-phase
// counter plus a halt latch, decoded into per-cycle datapath strobes.
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;

    logic is_hlt, is_skz, is_sto, is_jmp, alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Halting parks the counter on OP_ADDR; only reset leaves it.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    always_comb begin
        is_hlt = (opcode == OP_HLT);
        is_skz = (opcode == OP_SKZ);
        is_sto = (opcode == OP_STO);
        is_jmp = (opcode == OP_JMP);
        alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            unique case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = !is_hlt;
                    halt   = is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = alu_op;
                end
                PH_ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                PH_STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: driver pushes hand-written expected
// strobe vectors, a monitor pops and compares each cycle or on demand.
module tb_cpu_controller;

  // expected vector layout: {phase[2:0], sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  localparam int W = 12;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_tests;
  int           n_fail;
  event         chk_ev;

  // valid/ready: every entry pushed to exp_q is consumed by exactly one
  // monitor sample (next falling clock edge or an explicit chk_ev).

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_tests);
    $fatal(1, "watchdog");
  end

  // hand-written per-phase strobe tables {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
  logic [8:0] t_add [8];
  logic [8:0] t_skz1[8];
  logic [8:0] t_skz0[8];
  logic [8:0] t_sto [8];
  logic [8:0] t_jmp [8];
  logic [8:0] t_hlt [5];
  logic [8:0] s_rst;
  logic [8:0] s_halted;

  initial begin
    t_add  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
               9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    t_skz1 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
               9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
    t_skz0 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
               9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
    t_sto  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
               9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
    t_jmp  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
               9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000};
    t_hlt  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
               9'b000000001};
    s_rst    = 9'b100000000;
    s_halted = 9'b000000001;
  end

  // driver tasks
  task automatic push_exp(input logic [2:0] ph, input logic [8:0] s, input string tag);
    exp_q.push_back({ph, s});
    tag_q.push_back(tag);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input int which, input int n_ph,
                           input string name);
    logic [8:0] s;
    for (int p = 0; p < n_ph; p++) begin
      opcode = op;
      zero   = z;
      case (which)
        0: s = t_add[p];
        1: s = t_skz1[p];
        2: s = t_skz0[p];
        3: s = t_sto[p];
        4: s = t_jmp[p];
        default: s = t_hlt[p];
      endcase
      push_exp(3'(p), s, $sformatf("%s_ph%0d", name, p));
      if (p != n_ph - 1) next_cycle();
    end
  endtask

  // scoreboard monitor
  always begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    string        tag;
    @(negedge clk or chk_ev);
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      got = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got phase=%0d strobes=%b, required phase=%0d strobes=%b",
                 tag, got[11:9], got[8:0], e[11:9], e[8:0]);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    opcode  = 3'b010;
    zero    = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      push_exp(3'd0, s_rst, $sformatf("reset_hold%0d", i));
      next_cycle();
    end
    rst = 1'b0;

    run_instr(3'b010, 1'b0, 0, 8, "add");   next_cycle();
    run_instr(3'b001, 1'b1, 1, 8, "skz_z1"); next_cycle();
    run_instr(3'b001, 1'b0, 2, 8, "skz_z0"); next_cycle();
    run_instr(3'b110, 1'b0, 3, 8, "sto");   next_cycle();
    run_instr(3'b111, 1'b1, 4, 8, "jmp");   next_cycle();

    // STO interrupted by reset in phase 7, between clock edges
    run_instr(3'b110, 1'b0, 3, 8, "sto_cut");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push_exp(3'd0, s_rst, "sto_cut_async_rst");
    -> chk_ev;
    next_cycle();
    push_exp(3'd0, s_rst, "sto_cut_rst_edge");
    next_cycle();
    rst = 1'b0;
    run_instr(3'b010, 1'b0, 0, 8, "add_after_rst"); next_cycle();

    // HLT then 10 frozen cycles with disturbed inputs
    run_instr(3'b000, 1'b0, 5, 5, "hlt");
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      opcode = (i % 2 == 0) ? 3'b010 : 3'b111;
      zero   = (i % 3 == 0);
      push_exp(3'd4, s_halted, $sformatf("halted%0d", i));
      next_cycle();
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push_exp(3'd0, s_rst, "halt_async_rst");
    -> chk_ev;
    #1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    #1;

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
